hog_cell_hist: RTL and testbench

Cell-histogram accumulator upstream of the partial-histogram dual-port RAM in the HOG pipeline. Consumes a raster-ordered stream of per-pixel (orientation bin, gradient magnitude) pairs and sums each 8×8 cell into a 9-bin histogram. Partial sums for one cell row are parked in the RAM: write port a for write-back, read port b for prefetch. Completed cell histograms are emitted to the downstream block-normalisation stage.

---
 rtl/hog_pkg.sv | 17 +
 rtl/hog_cell_hist_if.sv | 12 +
 rtl/hist_vec_add.sv | 15 +
 rtl/hog_cell_hist.sv | 149 ++++++++++++++
 tb/tb_hog_cell_hist.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hog_pkg.sv
// Shared HOG constants and histogram packing helpers, common to the cell
// accumulator, the partial-histogram RAM and the block-normalisation stage.
package hog_pkg;

  localparam int NBIN    = 9;
  localparam int BIN_W   = 20;
  localparam int CELL_SZ = 8;
  localparam int HIST_W  = NBIN * BIN_W;

  typedef logic [BIN_W-1:0]  bin_t;
  typedef logic [HIST_W-1:0] hist_t;

  function automatic bin_t get_bin(input hist_t h, input int unsigned k);
    return h[k*BIN_W +: BIN_W];
  endfunction

endpackage

// File: rtl/hog_cell_hist_if.sv
// Raster pixel stream feeding the cell-histogram accumulator (no backpressure).
interface hog_cell_hist_if #(
  parameter int MAG_W = 12
);
  logic             frame_start;
  logic             pix_valid;
  logic [3:0]       pix_bin;
  logic [MAG_W-1:0] pix_mag;

  modport master (output frame_start, output pix_valid, output pix_bin, output pix_mag);
  modport slave  (input  frame_start, input  pix_valid, input  pix_bin, input  pix_mag);
endinterface

// File: rtl/hist_vec_add.sv
// NBIN-lane histogram adder; lanes with a clear enable pass i_a through.
module hist_vec_add
  import hog_pkg::*;
(
  input  hist_t            i_a,
  input  hist_t            i_b,
  input  logic [NBIN-1:0]  i_en,
  output hist_t            o_sum
);

  for (genvar k = 0; k < NBIN; k++) begin : g_lane
    assign o_sum[k*BIN_W +: BIN_W] = get_bin(i_a, k) + (i_en[k] ? get_bin(i_b, k) : {BIN_W{1'b0}});
  end

endmodule

// File: rtl/hog_cell_hist.sv
// Sums 8x8 pixel cells into 9-bin histograms; per-cell-row partials are parked
// in an external dual-port RAM (port a write-back, port b prefetch).
module hog_cell_hist
  import hog_pkg::*;
#(
  parameter int MAG_W     = 12,
  parameter int ADDR_W    = 6,
  parameter int CELL_COLS = 40,
  parameter int CELL_ROWS = 30
)(
  input  logic                clk,
  input  logic                rst_n,
  hog_cell_hist_if.slave      pix,
  output logic                o_ram_we,
  output logic [ADDR_W-1:0]   o_ram_addr_a,
  output logic [ADDR_W-1:0]   o_ram_addr_b,
  output hist_t               o_ram_wdata,
  input  hist_t               i_ram_rdata,
  output logic                o_cell_valid,
  output hist_t               o_cell_hist,
  output logic [ADDR_W-1:0]   o_cell_col,
  output logic [ADDR_W-1:0]   o_cell_row
);

  localparam logic [2:0]        PX_LAST  = 3'(CELL_SZ - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(CELL_COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(CELL_ROWS - 1);

  logic [2:0]        r_px;
  logic [ADDR_W-1:0] r_seg_col;
  logic [2:0]        r_ric;
  logic [ADDR_W-1:0] r_cr;
  hist_t             r_local;

  logic [2:0]        w_px, w_px_n, w_ric, w_ric_n;
  logic [ADDR_W-1:0] w_seg_col, w_seg_col_n, w_cr, w_cr_n;
  hist_t             w_local, w_local_n, w_pix_vec, w_local_pix, w_sum;
  logic [NBIN-1:0]   w_pix_en, w_ram_en;
  logic              w_seg_end;

  // frame_start makes the coincident pixel the first of a fresh frame
  assign w_px      = pix.frame_start ? 3'd0 : r_px;
  assign w_seg_col = pix.frame_start ? {ADDR_W{1'b0}} : r_seg_col;
  assign w_ric     = pix.frame_start ? 3'd0 : r_ric;
  assign w_cr      = pix.frame_start ? {ADDR_W{1'b0}} : r_cr;
  assign w_local   = pix.frame_start ? {HIST_W{1'b0}} : r_local;

  assign w_pix_vec = {NBIN{{(BIN_W-MAG_W){1'b0}}, pix.pix_mag}};
  assign w_ram_en  = {NBIN{w_ric != 3'd0}};
  assign w_seg_end = pix.pix_valid && (w_px == PX_LAST);

  // one-hot lane select; out-of-range bins select nothing
  always_comb begin
    w_pix_en = {NBIN{1'b0}};
    for (int k = 0; k < NBIN; k++) begin
      w_pix_en[k] = pix.pix_valid && (pix.pix_bin == 4'(k));
    end
  end

  hist_vec_add u_add_pix (
    .i_a   (w_local),
    .i_b   (w_pix_vec),
    .i_en  (w_pix_en),
    .o_sum (w_local_pix)
  );

  hist_vec_add u_add_ram (
    .i_a   (w_local_pix),
    .i_b   (i_ram_rdata),
    .i_en  (w_ram_en),
    .o_sum (w_sum)
  );

  // Raster position counters and local segment accumulator next-state
  always_comb begin
    w_px_n      = w_px;
    w_seg_col_n = w_seg_col;
    w_ric_n     = w_ric;
    w_cr_n      = w_cr;
    w_local_n   = w_local;
    if (pix.pix_valid) begin
      w_px_n = w_px + 3'd1;
      if (w_seg_end) begin
        w_local_n = {HIST_W{1'b0}};
        if (w_seg_col == COL_LAST) begin
          w_seg_col_n = {ADDR_W{1'b0}};
          w_ric_n     = w_ric + 3'd1;
          if (w_ric == PX_LAST) begin
            w_cr_n = (w_cr == ROW_LAST) ? {ADDR_W{1'b0}} : w_cr + ADDR_W'(1);
          end else begin
            w_cr_n = w_cr;
          end
        end else begin
          w_seg_col_n = w_seg_col + ADDR_W'(1);
        end
      end else begin
        w_local_n = w_local_pix;
      end
    end else begin
      w_px_n = w_px;
    end
  end

  // Counter and accumulator state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px      <= 3'd0;
      r_seg_col <= {ADDR_W{1'b0}};
      r_ric     <= 3'd0;
      r_cr      <= {ADDR_W{1'b0}};
      r_local   <= {HIST_W{1'b0}};
    end else begin
      r_px      <= w_px_n;
      r_seg_col <= w_seg_col_n;
      r_ric     <= w_ric_n;
      r_cr      <= w_cr_n;
      r_local   <= w_local_n;
    end
  end

  // Segment-end results: RAM write-back for inner rows, emission on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ram_we     <= 1'b0;
      o_ram_addr_a <= {ADDR_W{1'b0}};
      o_ram_wdata  <= {HIST_W{1'b0}};
      o_cell_valid <= 1'b0;
      o_cell_hist  <= {HIST_W{1'b0}};
      o_cell_col   <= {ADDR_W{1'b0}};
      o_cell_row   <= {ADDR_W{1'b0}};
    end else begin
      o_ram_we     <= w_seg_end && (w_ric != PX_LAST);
      o_cell_valid <= w_seg_end && (w_ric == PX_LAST);
      if (w_seg_end && (w_ric != PX_LAST)) begin
        o_ram_addr_a <= w_seg_col;
        o_ram_wdata  <= w_sum;
      end
      if (w_seg_end && (w_ric == PX_LAST)) begin
        o_cell_hist <= w_sum;
        o_cell_col  <= w_seg_col;
        o_cell_row  <= w_cr;
      end
    end
  end

  // prefetch address is the live column register
  assign o_ram_addr_b = r_seg_col;

endmodule

// File: tb/tb_hog_cell_hist.sv
// Randomised bench for hog_cell_hist with a behavioural RAM and a cell-level
// reference model indexed directly from each pixel's frame position.
module tb_hog_cell_hist;
  import hog_pkg::*;

  localparam int CC = 4;
  localparam int CR = 2;
  localparam int FRAME_PIX = 64 * CC * CR;

  typedef struct packed {
    logic [5:0] col;
    logic [5:0] row;
    hist_t      d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_we, cell_valid;
  logic [5:0] ram_addr_a, ram_addr_b, cell_col, cell_row;
  hist_t ram_wdata, ram_rdata, cell_hist;

  hog_cell_hist_if #(.MAG_W(12)) pif ();

  hog_cell_hist #(.MAG_W(12), .ADDR_W(6), .CELL_COLS(CC), .CELL_ROWS(CR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix          (pif),
    .o_ram_we     (ram_we),
    .o_ram_addr_a (ram_addr_a),
    .o_ram_addr_b (ram_addr_b),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_cell_valid (cell_valid),
    .o_cell_hist  (cell_hist),
    .o_cell_col   (cell_col),
    .o_cell_row   (cell_row)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  hist_t mem [0:63];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_wdata;
    ram_rdata <= mem[ram_addr_b];
  end

  ev_t obs_wr_q[$], obs_cell_q[$], exp_wr_q[$], exp_cell_q[$];

  always begin
    @(posedge clk);
    #1;
    if (ram_we)     obs_wr_q.push_back(ev_t'{ram_addr_a, 6'd0, ram_wdata});
    if (cell_valid) obs_cell_q.push_back(ev_t'{cell_col, cell_row, cell_hist});
  end

  int m_n;
  int m_acc [0:CC-1][0:NBIN-1];

  task automatic model_clear();
    m_n = 0;
    for (int c = 0; c < CC; c++)
      for (int k = 0; k < NBIN; k++) m_acc[c][k] = 0;
  endtask

  task automatic model_step(input int b, input int m);
    int px, sc, ric, cr;
    hist_t v;
    px  = m_n % 8;
    sc  = (m_n / 8) % CC;
    ric = (m_n / (8 * CC)) % 8;
    cr  = (m_n / (64 * CC)) % CR;
    if (b < NBIN) m_acc[sc][b] += m;
    if (px == 7) begin
      for (int k = 0; k < NBIN; k++) v[k*BIN_W +: BIN_W] = BIN_W'(m_acc[sc][k]);
      if (ric < 7) exp_wr_q.push_back(ev_t'{6'(sc), 6'd0, v});
      else begin
        exp_cell_q.push_back(ev_t'{6'(sc), 6'(cr), v});
        for (int k = 0; k < NBIN; k++) m_acc[sc][k] = 0;
      end
    end
    m_n = (m_n + 1) % FRAME_PIX;
  endtask

  task automatic drive_pix(input bit fs, input bit v, input int b, input int m);
    @(negedge clk);
    pif.frame_start = fs;
    pif.pix_valid   = v;
    pif.pix_bin     = 4'(b);
    pif.pix_mag     = 12'(m);
    if (fs) model_clear();
    if (v)  model_step(b, m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_pix(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 4095));
  endtask

  task automatic clear_queues();
    obs_wr_q.delete(); obs_cell_q.delete(); exp_wr_q.delete(); exp_cell_q.delete();
  endtask

  task automatic test_reset();
    logic [5:0] zero_out;
    n_vec++;
    if ({ram_we, ram_addr_a, ram_addr_b, ram_wdata, cell_valid, cell_hist, cell_col, cell_row} !== '0) begin
      n_err++; $display("FAIL reset_state: outputs nonzero got we=%b cv=%b", ram_we, cell_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive_pix(i == 0, 1'b1, $urandom_range(0, 8), $urandom_range(0, 4095));
    @(posedge clk); #2;
    n_vec++;
    if (ram_we !== 1'b1) begin n_err++; $display("FAIL pending_we: got %b want 1", ram_we); end
    rst_n = 1'b0;
    #1;
    zero_out = 6'd0;
    n_vec++;
    if ({ram_we, ram_addr_a, ram_addr_b, ram_wdata, cell_valid, cell_hist, cell_col, cell_row} !== '0) begin
      n_err++; $display("FAIL async_reset: outputs nonzero got we=%b addr_a=%0d want 0", ram_we, ram_addr_a);
    end
    @(negedge clk);
    pif.pix_valid = 1'b0; pif.frame_start = 1'b0;
    rst_n = 1'b1;
    model_clear(); clear_queues();
    for (int i = 0; i < 7; i++) drive_pix(1'b0, 1'b1, $urandom_range(0, 8), $urandom_range(0, 4095));
    idle(4);
    n_vec++;
    if (obs_wr_q.size() != 0) begin n_err++; $display("FAIL early_we: got %0d writes want 0", obs_wr_q.size()); end
    drive_pix(1'b0, 1'b1, $urandom_range(0, 8), $urandom_range(0, 4095));
    idle(3);
    n_vec++;
    if (obs_wr_q.size() != 1 || exp_wr_q.size() != 1 || obs_wr_q[0] !== exp_wr_q[0]) begin
      n_err++; $display("FAIL post_reset_wr: got %0d writes want 1 matching model", obs_wr_q.size());
    end
    if (zero_out !== 6'd0) $display("note: unexpected");
  endtask

  task automatic test_constant();
    hist_t want;
    idle(3); clear_queues();
    want = '0;
    want[3*BIN_W +: BIN_W] = 20'd64;
    for (int i = 0; i < FRAME_PIX; i++) drive_pix(i == 0, 1'b1, 3, 1);
    idle(3);
    n_vec++;
    if (obs_cell_q.size() != 8) begin n_err++; $display("FAIL const_count: got %0d want 8", obs_cell_q.size()); end
    for (int i = 0; i < obs_cell_q.size() && i < 8; i++) begin
      n_vec++;
      if (obs_cell_q[i] !== ev_t'{6'(i % CC), 6'(i / CC), want}) begin
        n_err++; $display("FAIL const_cell[%0d]: got %h want %h", i, obs_cell_q[i], ev_t'{6'(i % CC), 6'(i / CC), want});
      end
    end
  endtask

  task automatic test_gradient();
    idle(3); clear_queues();
    for (int i = 0; i < FRAME_PIX; i++) drive_pix(i == 0, 1'b1, i % 9, 4095);
    idle(3);
    n_vec++;
    if (obs_cell_q.size() != exp_cell_q.size()) begin
      n_err++; $display("FAIL grad_count: got %0d want %0d", obs_cell_q.size(), exp_cell_q.size());
    end
    for (int i = 0; i < obs_cell_q.size() && i < exp_cell_q.size(); i++) begin
      n_vec++;
      if (obs_cell_q[i] !== exp_cell_q[i]) begin
        n_err++; $display("FAIL grad_cell[%0d]: got %h want %h", i, obs_cell_q[i], exp_cell_q[i]);
      end
    end
  endtask

  task automatic test_writeback();
    int b, m;
    hist_t w8, w16;
    idle(3); clear_queues();
    b = $urandom_range(0, 8);
    m = $urandom_range(1, 4095);
    w8 = '0;  w8[b*BIN_W +: BIN_W]  = BIN_W'(8 * m);
    w16 = '0; w16[b*BIN_W +: BIN_W] = BIN_W'(16 * m);
    for (int i = 0; i < 8 * (CC + 1); i++) drive_pix(i == 0, 1'b1, b, m);
    idle(3);
    n_vec++;
    if (obs_wr_q.size() != CC + 1) begin n_err++; $display("FAIL wb_count: got %0d want %0d", obs_wr_q.size(), CC + 1); end
    else begin
      n_vec++;
      if (obs_wr_q[0] !== ev_t'{6'd0, 6'd0, w8}) begin
        n_err++; $display("FAIL wb_row0: got %h want %h", obs_wr_q[0], ev_t'{6'd0, 6'd0, w8});
      end
      n_vec++;
      if (obs_wr_q[CC] !== ev_t'{6'd0, 6'd0, w16}) begin
        n_err++; $display("FAIL wb_row1: got %h want %h", obs_wr_q[CC], ev_t'{6'd0, 6'd0, w16});
      end
    end
  endtask

  task automatic test_gaps_invalid();
    int b;
    idle(3); clear_queues();
    for (int i = 0; i < FRAME_PIX; i++) begin
      while ($urandom_range(0, 3) == 0) idle(1);
      b = ($urandom_range(0, 4) == 0) ? 12 : $urandom_range(0, 8);
      drive_pix(i == 0, 1'b1, b, $urandom_range(0, 4095));
    end
    idle(3);
    n_vec++;
    if (obs_cell_q.size() != exp_cell_q.size() || obs_wr_q.size() != exp_wr_q.size()) begin
      n_err++; $display("FAIL gap_count: got %0d/%0d want %0d/%0d", obs_cell_q.size(), obs_wr_q.size(), exp_cell_q.size(), exp_wr_q.size());
    end
    for (int i = 0; i < obs_cell_q.size() && i < exp_cell_q.size(); i++) begin
      n_vec++;
      if (obs_cell_q[i] !== exp_cell_q[i]) begin
        n_err++; $display("FAIL gap_cell[%0d]: got %h want %h", i, obs_cell_q[i], exp_cell_q[i]);
      end
    end
    for (int i = 0; i < obs_wr_q.size() && i < exp_wr_q.size(); i++) begin
      n_vec++;
      if (obs_wr_q[i] !== exp_wr_q[i]) begin
        n_err++; $display("FAIL gap_wr[%0d]: got %h want %h", i, obs_wr_q[i], exp_wr_q[i]);
      end
    end
  endtask

  task automatic test_frame_restart();
    idle(3); clear_queues();
    for (int i = 0; i < 5 * 8 * CC + 13; i++) drive_pix(i == 0, 1'b1, $urandom_range(0, 8), $urandom_range(0, 4095));
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FRAME_PIX; i++) drive_pix(i == 0, 1'b1, $urandom_range(0, 8), $urandom_range(0, 4095));
    idle(3);
    n_vec++;
    if (obs_cell_q.size() != 16 || exp_cell_q.size() != 16) begin
      n_err++; $display("FAIL restart_count: got %0d want 16", obs_cell_q.size());
    end
    for (int i = 0; i < obs_cell_q.size() && i < exp_cell_q.size(); i++) begin
      n_vec++;
      if (obs_cell_q[i] !== exp_cell_q[i]) begin
        n_err++; $display("FAIL restart_cell[%0d]: got %h want %h", i, obs_cell_q[i], exp_cell_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hist_t tmp;
    rst_n = 1'b0;
    pif.frame_start = 1'b0; pif.pix_valid = 1'b0; pif.pix_bin = 4'd0; pif.pix_mag = 12'd0;
    for (int a = 0; a < 64; a++) begin
      tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      mem[a] = tmp;
    end
    model_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_constant();
    test_gradient();
    test_writeback();
    test_gaps_invalid();
    test_frame_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
